// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes, mux selects and the control bundle.
// Pure definitions; no logic, no latency, no flow control.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_BNE    = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode of controller state (plus mem_ready for the FETCH writes); purely combinational.
// No backpressure of its own: FETCH holds off ir/pc writes until mem_ready.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            // BEQ and BNE share the compare datapath; only the branch sense differs.
            S_BEQ, S_BNE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = (state == S_BNE);
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_TRAP:   ctrl.illegal   = 1'b1;
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: state register + next-state; outputs are a Moore decode of state.
// FETCH/MEMRD/MEMWR stall one cycle per mem_ready=0 when MEM_WAIT=1.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int MEM_WAIT   = 1,
    parameter int ENABLE_EXT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    logic   rdy;
    logic   ext_on;
    ctrl_t  ctrl;

    assign rdy    = (MEM_WAIT == 0) ? 1'b1 : mem_ready;
    assign ext_on = (ENABLE_EXT != 0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = ext_on ? S_ADDIEX : S_TRAP;
                    OP_BNE:       state_d = ext_on ? S_BNE : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (rdy) state_d = S_MEMWB;
            S_MEMWR:  if (rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            // Single-cycle tails and unused codes 14/15 all return to FETCH.
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (rdy),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign branch_ne     = ctrl.branch_ne;
    assign iord          = ctrl.iord;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign alu_src_b     = ctrl.alu_src_b;
    assign illegal       = ctrl.illegal;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: three parameterisations run in lockstep against an instruction-path model.
// Random opcodes, mem_ready stalls and mid-instruction resets.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       illegal;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;

    out_t [2:0]       got;
    logic [2:0][3:0]  st;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: ENABLE_EXT=0; 2: MEM_WAIT=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MW = (g == 2) ? 0 : 1;
        localparam int EE = (g == 1) ? 0 : 1;
        out_t       o;
        logic [3:0] s;
        multicycle_controller #(.MEM_WAIT(MW), .ENABLE_EXT(EE)) u_dut (
            .clk           (clk),
            .reset         (reset),
            .opcode        (opcode),
            .mem_ready     (mem_ready),
            .pc_write      (o.pc_write),
            .pc_write_cond (o.pc_write_cond),
            .branch_ne     (o.branch_ne),
            .iord          (o.iord),
            .mem_read      (o.mem_read),
            .mem_write     (o.mem_write),
            .ir_write      (o.ir_write),
            .mem_to_reg    (o.mem_to_reg),
            .alu_src_a     (o.alu_src_a),
            .reg_write     (o.reg_write),
            .reg_dst       (o.reg_dst),
            .pc_source     (o.pc_source),
            .alu_op        (o.alu_op),
            .alu_src_b     (o.alu_src_b),
            .illegal       (o.illegal),
            .state         (s)
        );
        assign got[g] = o;
        assign st[g]  = s;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Whole-instruction state path: {length, s5..s0}, one nibble per visited state.
    function automatic logic [27:0] mk(input int len, input int s2, input int s3, input int s4);
        logic [3:0] l4, a, b, c;
        l4 = 4'(len); a = 4'(s2); b = 4'(s3); c = 4'(s4);
        return {l4, 4'd0, c, b, a, 4'd1, 4'd0};
    endfunction

    function automatic logic [27:0] path_of(input logic [5:0] opc, input bit ext);
        case (opc)
            6'h23: return mk(5, 2, 3, 4);
            6'h2B: return mk(4, 2, 5, 0);
            6'h00: return mk(4, 6, 7, 0);
            6'h04: return mk(3, 8, 0, 0);
            6'h02: return mk(3, 9, 0, 0);
            6'h08: return ext ? mk(4, 10, 11, 0) : mk(3, 13, 0, 0);
            6'h05: return ext ? mk(3, 12, 0, 0) : mk(3, 13, 0, 0);
            default: return mk(3, 13, 0, 0);
        endcase
    endfunction

    function automatic out_t expect_out(input int s, input bit rdy);
        out_t o;
        o = '0;
        case (s)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            1:  o.alu_src_b = 2'b11;
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.iord = 1; end
            4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
            5:  begin o.mem_write = 1; o.iord = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_write = 1; o.reg_dst = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; end
            9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            11: o.reg_write = 1;
            12: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_write_cond = 1; o.pc_source = 2'b01; o.branch_ne = 1; end
            13: o.illegal = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    logic [27:0] plan [3];
    int          pidx [3];

    initial begin
        logic [5:0] ops [8];
        int  cyc;
        int  stall_pct;
        bit  first;
        ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h00; ops[3] = 6'h04;
        ops[4] = 6'h02; ops[5] = 6'h08; ops[6] = 6'h05; ops[7] = 6'h3F;
        cyc   = 0;
        first = 1'b1;
        for (int ep = 0; ep < 48; ep++) begin
            stall_pct = (ep % 3 == 0) ? 0 : int'($urandom_range(10, 50));
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (c == 0)
                    opcode = (ep < 16) ? ops[ep % 8] :
                             ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
                reset     = (c == 0) || ($urandom_range(0, 39) == 0);
                mem_ready = ($urandom_range(0, 99) >= stall_pct);
                #1;
                for (int i = 0; i < 3; i++) begin
                    int  s;
                    bit  ext, wt, rdy;
                    ext = (i != 1);
                    wt  = (i != 2);
                    rdy = wt ? mem_ready : 1'b1;
                    if (!first) begin
                        s = int'(plan[i][4*pidx[i] +: 4]);
                        check($sformatf("d%0d_state_c%0d", i, cyc), 32'(st[i]), 32'(s));
                        check($sformatf("d%0d_outs_c%0d_s%0d", i, cyc, s), 32'(got[i]), 32'(expect_out(s, rdy)));
                    end else begin
                        s = 0;
                    end
                    if (reset) begin
                        plan[i] = path_of(opcode, ext);
                        pidx[i] = 0;
                    end else if (!(wt && !mem_ready && (s == 0 || s == 3 || s == 5))) begin
                        pidx[i]++;
                        if (pidx[i] == int'(plan[i][27:24])) begin
                            pidx[i] = 0;
                            plan[i] = path_of(opcode, ext);
                        end
                    end
                end
                first = 1'b0;
                cyc++;
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1: 1 = fetch/load/store states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 SHALL have parameter ENABLE_EXT, default 1: 1 = addi (0x08) and bne (0x05) decoded; 0 = both treated as illegal.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port opcode  in  6  instruction register bits [31:26].
REQ-006 SHALL have port mem_ready  in  1  memory access completes this cycle.
REQ-007 SHALL have ports pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst, each  out  1  datapath strobes/selects.
REQ-008 SHALL have ports pc_source, alu_op, alu_src_b, each  out  2  datapath mux selects and ALU-control opcode.
REQ-009 SHALL have port illegal  out  1  one-cycle pulse on an undecoded opcode.
REQ-010 SHALL have port state  out  4  current state, for debug.

Function
REQ-011 SHALL hold a registered 4-bit state; all outputs SHALL be combinational (Moore) decodes of state plus mem_ready only.
REQ-012 States SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11, BNE=12, TRAP=13; codes 14-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-013 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; it SHALL drive ir_write=1 and pc_write=1 only when mem_ready=1.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode: 0x23/0x2B->MEMADR, 0x00->EXEC, 0x04->BEQ, 0x02->JUMP, 0x08->ADDIEX, 0x05->BNE, any other->TRAP.
REQ-015 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if opcode=0x23, else MEMWR.
REQ-016 MEMRD SHALL drive mem_read=1, iord=1; MEMWR SHALL drive mem_write=1, iord=1; both SHALL advance (MEMRD->MEMWB, MEMWR->FETCH) only when mem_ready=1, otherwise hold.
REQ-017 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-018 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, next ALUWB; ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, next FETCH.
REQ-019 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne=0; BNE identical except branch_ne=1; both next FETCH.
REQ-020 JUMP SHALL drive pc_write=1, pc_source=10; next FETCH.
REQ-021 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, next ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, next FETCH.
REQ-022 TRAP SHALL drive illegal=1, all strobes 0; next FETCH.
REQ-023 Any strobe/select not listed for a state SHALL be 0.
REQ-024 Latencies with mem_ready held 1: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4 cycles; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-025 mem_write and reg_write SHALL never be 1 in the same cycle; pc_write SHALL never be 1 during a FETCH wait cycle.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=FETCH regardless of current state or mem_ready, including mid-wait in MEMRD/MEMWR.
REQ-027 While state=FETCH after reset, outputs SHALL equal REQ-013 values; no write strobe other than the FETCH pc_write/ir_write SHALL be 1.

Structure
REQ-028 State codes, opcode constants and alu_op/pc_source/alu_src_b encodings SHALL reside in shared package mc_pkg.
REQ-029 Output decode SHALL be a sub-module mc_output_decode (state, mem_ready in; strobes out); the state register and next-state logic stay in multicycle_controller.

Verification
REQ-030 reset, then opcode=0x23, mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-031 opcode=0x2B, mem_ready=0 for 3 cycles in MEMWR -> state holds 5 for 3 cycles with mem_write=1, then FETCH; reg_write never 1.
REQ-032 FETCH with mem_ready=0 for 2 cycles -> pc_write=ir_write=0 for those cycles, mem_read=1; both 1 in cycle mem_ready rises.
REQ-033 opcode=0x05 with ENABLE_EXT=1 -> states 0,1,12,0 with branch_ne=1, pc_write_cond=1 in 12; with ENABLE_EXT=0 -> 0,1,13,0, illegal=1 one cycle.
REQ-034 opcode=0x3F -> TRAP, illegal pulse, back to FETCH; reset asserted while in MEMRD waiting -> next state 0.
REQ-035 MEM_WAIT=0, opcode=0x00, mem_ready=0 -> states 0,1,6,7,0; reg_dst=1, reg_write=1 in 7.
